mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory (64-bit words) between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the fetch/datapath logic and the memory array, replacing separate instruction and data ports.
- Sequences each access through a fixed-latency issue/wait/respond FSM.
- Arbitrates simultaneous requests round-robin.

Parameters:
- ADDR_BITS, 6, word address width of both requesters and the memory port.
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  ADDR_BITS  fetch word address, stable while i_req
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetched instruction = captured mem_rdata[31:0]
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_BITS  data word address
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  64  load result; unchanged by stores
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write strobe, only together with mem_en
- mem_addr  out  ADDR_BITS  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, busy=0.
  - Internal state: state=IDLE, last_owner=DATA (so fetch wins the first tie).
  - mem_en and mem_we are forced 0 in any cycle where reset is high. A store in ISSUE during reset does not commit.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch owner, address, we and wdata; next state is ISSUE.
  - Only one requester: grant it.
  - Both requesting: grant the requester that is not last_owner.
- ISSUE:
  - Drive mem_en=1, mem_addr=latched address.
  - mem_we=1 only for a data store; mem_wdata=latched wdata.
  - Load the latency counter with MEM_LAT; next state is WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 1: capture mem_rdata at the edge and go to RESP.
  - Capture target: i_rdata for fetch, d_rdata for a load, nothing for a store.
- RESP:
  - Pulse the owner's ack for exactly one cycle.
  - Update last_owner to the owner just served; next state is IDLE.
- Latency: a request first seen in IDLE at cycle 0 produces mem_en at cycle 1 and ack at cycle MEM_LAT+2.
- Throughput: one access per MEM_LAT+3 cycles.
- Handshake contract:
  - A requester deasserts req in the cycle after ack, or holds it high for a new back-to-back access.
  - req high in IDLE is always treated as a new request.
  - Dropping req before ack is illegal; the behaviour is undefined but must not hang the FSM.
  - The access completes regardless.
- A request arriving during ISSUE/WAIT/RESP waits; it is evaluated in the next IDLE.
- No starvation: under continuous requests from both sides, grants strictly alternate I, D, I, D.
- Outputs that are not driven:
  - mem_addr/mem_wdata outside ISSUE hold their latched values.
  - mem_en=mem_we=0 outside ISSUE.
- Reset mid-operation discards the in-flight access: no ack, no capture.

Optional Feature:
- Macro: MEM_ARB_DATA_PRIORITY_EN.
- Defined: fixed priority. d_req beats i_req on every tie, and last_owner is ignored. Fetch can starve under continuous data traffic.
- Undefined (default): round-robin as described above.

Decomposition:
- Package mem_arb_pkg:
  - State encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Owner encoding: OWN_I=1'b0, OWN_D=1'b1.
  - Counter width constant LAT_W=4.
- Sub-module mem_arb_rr_pick (combinational grant selection):
  - Inputs: i_req, d_req, last_owner.
  - Outputs: grant_valid, grant_owner.
  - The macro variant is implemented inside it.

Test Plan:
- MEM_LAT=1; memory word 3 = 14; single load d_addr=3 at cycle 0 -> mem_en at cycle 1 with mem_addr=3 and mem_we=0; d_ack at cycle 3 with d_rdata=14; i_ack stays 0.
- Store d_addr=13, d_wdata=25 -> one cycle of mem_en=mem_we=1 with mem_wdata=25; d_ack at cycle 3; d_rdata unchanged; a following load of 13 returns 25.
- i_req and d_req both raised at cycle 0, held after each ack -> grant order I, D, I, D; acks at cycles 3, 7, 11, 15. With the macro defined: D, D, D, and i_ack never asserts.
- MEM_LAT=4; fetch at i_addr=0 with memory word 0 = 0x00208463 -> mem_en at cycle 1; i_ack at cycle 6 with i_rdata=32'h00208463.
- reset asserted during the ISSUE cycle of a store to word 5 (old value 7) -> mem_we=0 that cycle; word 5 stays 7; no ack; next cycle state=IDLE, busy=0, acks=0, rdata regs=0.
- Idle bench with no requests for 20 cycles -> busy=0, mem_en=0, no ack pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter (mem_port_arbiter).
// Optional build macro MEM_ARB_DATA_PRIORITY_EN is consumed by mem_arb_rr_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational grant selection between fetch and data requesters.
// MEM_ARB_DATA_PRIORITY_EN: data always wins ties; otherwise round-robin on last_owner.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
`ifdef MEM_ARB_DATA_PRIORITY_EN
        if (d_req) begin
            grant_owner = OWN_D;
        end
`else
        if (i_req && d_req) begin
            // Tie goes to whoever was not served last.
            grant_owner = ~last_owner;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64-bit memory between instruction fetch and data load/store.
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP. Build macro: MEM_ARB_DATA_PRIORITY_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic                 i_ack,
    output logic [31:0]          i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [63:0]          d_wdata,
    output logic                 d_ack,
    output logic [63:0]          d_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [63:0]          mem_wdata,
    input  logic [63:0]          mem_rdata,
    output logic                 busy,
    output logic [1:0]           o_dbg_state
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_owner;
    logic                   r_last_owner;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_we;
    logic [63:0]            r_wdata;
    logic [LAT_W-1:0]       r_cnt;
    logic [31:0]            r_i_rdata;
    logic [63:0]            r_d_rdata;
    logic                   w_grant_valid;
    logic                   w_grant_owner;
    logic                   w_last_wait;

    mem_arb_rr_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // Counter is loaded with MEM_LAT in ISSUE; "<=" keeps a corrupt count from hanging WAIT.
    assign w_last_wait = (r_cnt <= LAT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mem_en       = ~reset;
                mem_we       = ~reset & r_we;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (w_last_wait) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                i_ack        = ~reset & (r_owner == OWN_I);
                d_ack        = ~reset & (r_owner == OWN_D);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWN_I;
            r_last_owner <= OWN_D;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        r_addr  <= (w_grant_owner == OWN_D) ? d_addr : i_addr;
                        r_we    <= (w_grant_owner == OWN_D) & d_we;
                        r_wdata <= d_wdata;
                    end
                end
                ISSUE: r_cnt <= LAT_W'(MEM_LAT);
                WAIT: begin
                    r_cnt <= r_cnt - LAT_W'(1);
                    if (w_last_wait) begin
                        if (r_owner == OWN_I) begin
                            r_i_rdata <= mem_rdata[31:0];
                        end else if (!r_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: r_last_owner <= r_owner;
                default: ;
            endcase
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4), each with a latency memory model.
// Expectations come from a transaction-level model: shadow memory, last served owner, spec latencies.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int L1 = 1;
    localparam int L4 = 4;
    localparam logic OI = 1'b0;
    localparam logic OD = 1'b1;
    localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk;
    logic reset;

    logic          i_req, d_req, d_we, i_ack, d_ack, mem_en, mem_we, busy;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [31:0]   i_rdata;
    logic [63:0]   d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;

    logic          i_req_4, d_req_4, d_we_4, i_ack_4, d_ack_4, mem_en_4, mem_we_4, busy_4;
    logic [AW-1:0] i_addr_4, d_addr_4, mem_addr_4;
    logic [31:0]   i_rdata_4;
    logic [63:0]   d_wdata_4, d_rdata_4, mem_wdata_4, mem_rdata_4;
    logic [1:0]    dbg_state_4;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] sh1 [64];
    logic [63:0] sh4 [64];
    logic [63:0] env1 [64];
    logic [63:0] env4 [64];
    logic [63:0] pipe1 [16];
    logic [63:0] pipe4 [16];
    logic          pre_en;
    logic [AW-1:0] pre_addr;

    logic        m_last;
    logic [31:0] m_irdata;
    logic [63:0] m_drdata;

    mem_port_arbiter #(.ADDR_BITS(AW), .MEM_LAT(L1)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .o_dbg_state(dbg_state)
    );

    mem_port_arbiter #(.ADDR_BITS(AW), .MEM_LAT(L4)) u_dut4 (
        .clk(clk), .reset(reset),
        .i_req(i_req_4), .i_addr(i_addr_4), .i_ack(i_ack_4), .i_rdata(i_rdata_4),
        .d_req(d_req_4), .d_we(d_we_4), .d_addr(d_addr_4), .d_wdata(d_wdata_4),
        .d_ack(d_ack_4), .d_rdata(d_rdata_4),
        .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4),
        .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata_4),
        .busy(busy_4), .o_dbg_state(dbg_state_4)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory models: read data valid MEM_LAT cycles after mem_en ----------------
    always @(posedge clk) begin
        if (pre_en) begin
            env1[pre_addr] <= sh1[pre_addr];
            env4[pre_addr] <= sh4[pre_addr];
        end else begin
            if (mem_en && mem_we) env1[mem_addr] <= mem_wdata;
            if (mem_en_4 && mem_we_4) env4[mem_addr_4] <= mem_wdata_4;
        end
        pipe1[0] <= mem_en ? env1[mem_addr] : POISON;
        pipe4[0] <= mem_en_4 ? env4[mem_addr_4] : POISON;
        for (int k = 1; k < 16; k++) begin
            pipe1[k] <= pipe1[k-1];
            pipe4[k] <= pipe4[k-1];
        end
    end
    assign mem_rdata   = pipe1[L1-1];
    assign mem_rdata_4 = pipe4[L4-1];

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tie_winner(input logic last);
`ifdef MEM_ARB_DATA_PRIORITY_EN
        return OD;
`else
        return ~last;
`endif
    endfunction

    // One access (or one simultaneous pair) on the MEM_LAT=1 instance, starting in an IDLE cycle.
    task automatic run_txn(input bit ui, input bit ud, input logic [AW-1:0] ia,
                           input logic [AW-1:0] da, input bit we, input logic [63:0] wd);
        bit          both;
        logic        fo;
        logic        o;
        int          ti, td, last;
        bit          iss;
        logic [31:0] exp_i;
        logic [63:0] exp_d;
        both  = ui && ud;
        fo    = both ? tie_winner(m_last) : (ud ? OD : OI);
        ti    = -1;
        td    = -1;
        if (ui) ti = (both && fo == OD) ? 2*L1+5 : L1+2;
        if (ud) td = (both && fo == OI) ? 2*L1+5 : L1+2;
        last  = (ti > td) ? ti : td;
        exp_d = sh1[da];
        exp_i = (both && fo == OD && we && da == ia) ? wd[31:0] : sh1[ia][31:0];
        i_addr = ia; d_addr = da; d_we = we; d_wdata = wd;
        i_req = ui; d_req = ud;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            chk("i_ack", 64'(i_ack), 64'(c == ti));
            chk("d_ack", 64'(d_ack), 64'(c == td));
            chk("i_rdata", 64'(i_rdata), 64'((ti >= 0 && c >= ti) ? exp_i : m_irdata));
            chk("d_rdata", d_rdata, (td >= 0 && c >= td && !we) ? exp_d : m_drdata);
            chk("busy", 64'(busy), 64'(!(c == 0 || (both && c == L1+3))));
            iss = (c == 1) || (both && c == L1+4);
            chk("mem_en", 64'(mem_en), 64'(iss));
            if (iss) begin
                o = (c == 1) ? fo : ~fo;
                chk("mem_addr", 64'(mem_addr), 64'((o == OD) ? da : ia));
                chk("mem_we", 64'(mem_we), 64'(o == OD && we));
                if (o == OD && we) chk("mem_wdata", mem_wdata, wd);
            end else begin
                chk("mem_we_idle", 64'(mem_we), 64'(0));
            end
            @(posedge clk); #1;
            if (c == ti) i_req = 1'b0;
            if (c == td) d_req = 1'b0;
        end
        if (ti >= 0) m_irdata = exp_i;
        if (td >= 0 && !we) m_drdata = exp_d;
        if (td >= 0 && we) sh1[da] = wd;
        m_last = both ? ~fo : (ud ? OD : OI);
    endtask

    // One access on the MEM_LAT=4 instance.
    task automatic run4(input bit is_fetch, input logic [AW-1:0] a, input bit we, input logic [63:0] wd);
        logic [63:0] exp_v;
        exp_v = sh4[a];
        i_addr_4 = a; d_addr_4 = a; d_we_4 = we; d_wdata_4 = wd;
        i_req_4 = is_fetch; d_req_4 = !is_fetch;
        for (int c = 0; c <= L4+2; c++) begin
            @(negedge clk);
            chk("l4_mem_en", 64'(mem_en_4), 64'(c == 1));
            chk("l4_i_ack", 64'(i_ack_4), 64'(is_fetch && c == L4+2));
            chk("l4_d_ack", 64'(d_ack_4), 64'(!is_fetch && c == L4+2));
            if (c == 1) chk("l4_mem_addr", 64'(mem_addr_4), 64'(a));
            if (c == L4+2 && is_fetch) chk("l4_i_rdata", 64'(i_rdata_4), 64'(exp_v[31:0]));
            if (c == L4+2 && !is_fetch && !we) chk("l4_d_rdata", d_rdata_4, exp_v);
            @(posedge clk); #1;
            if (c == L4+2) begin i_req_4 = 1'b0; d_req_4 = 1'b0; end
        end
        if (!is_fetch && we) sh4[a] = wd;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [AW-1:0] ra, rb;
        int            sel;
        logic          own_k;
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        i_req_4 = 0; d_req_4 = 0; d_we_4 = 0; i_addr_4 = '0; d_addr_4 = '0; d_wdata_4 = '0;
        m_last = OD; m_irdata = '0; m_drdata = '0;
        for (int a = 0; a < 64; a++) begin
            sh1[a] = {$urandom, $urandom};
            sh4[a] = {$urandom, $urandom};
        end
        sh1[3] = 64'd14;
        sh4[0] = {$urandom, 32'h0020_8463};
        pre_en = 1'b1;
        for (int a = 0; a < 64; a++) begin
            pre_addr = AW'(a);
            @(posedge clk); #1;
        end
        pre_en = 1'b0;

        @(negedge clk);
        chk("rst_i_ack", 64'(i_ack), 64'(0));
        chk("rst_d_ack", 64'(d_ack), 64'(0));
        chk("rst_i_rdata", 64'(i_rdata), 64'(0));
        chk("rst_d_rdata", d_rdata, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Load word 3, store 25 to word 13, load it back.
        run_txn(0, 1, '0, 6'd3, 0, 64'd0);
        run_txn(0, 1, '0, 6'd13, 1, 64'd25);
        run_txn(0, 1, '0, 6'd13, 0, 64'd0);

        // Both requesters held continuously for four grants.
        i_addr = 6'd7; d_addr = 6'd9; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            own_k = tie_winner(m_last);
`ifndef MEM_ARB_DATA_PRIORITY_EN
            if ((c / 4) % 2 == 1) own_k = ~own_k;
`endif
            chk("alt_i_ack", 64'(i_ack), 64'(c % 4 == 3 && own_k == OI));
            chk("alt_d_ack", 64'(d_ack), 64'(c % 4 == 3 && own_k == OD));
            if (c % 4 == 3 && own_k == OI) m_irdata = sh1[7][31:0];
            if (c % 4 == 3 && own_k == OD) m_drdata = sh1[9];
            chk("alt_i_rdata", 64'(i_rdata), 64'(m_irdata));
            chk("alt_d_rdata", d_rdata, m_drdata);
            @(posedge clk); #1;
            if (c == 15) begin
                i_req = 1'b0; d_req = 1'b0;
                m_last = own_k;
            end
        end

        // Reset during the ISSUE cycle of a store to word 5 holding 7.
        run_txn(0, 1, '0, 6'd5, 1, 64'd7);
        d_addr = 6'd5; d_we = 1'b1; d_wdata = 64'd99; d_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_en", 64'(mem_en), 64'(0));
        chk("rstmid_mem_we", 64'(mem_we), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("rstmid_state", 64'(dbg_state), 64'(0));
        chk("rstmid_busy", 64'(busy), 64'(0));
        chk("rstmid_i_ack", 64'(i_ack), 64'(0));
        chk("rstmid_d_ack", 64'(d_ack), 64'(0));
        chk("rstmid_i_rdata", 64'(i_rdata), 64'(0));
        chk("rstmid_d_rdata", d_rdata, 64'(0));
        m_last = OD; m_irdata = '0; m_drdata = '0;
        @(posedge clk); #1;
        run_txn(0, 1, '0, 6'd5, 0, 64'd0);

        // Idle: nothing moves for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_mem_en", 64'(mem_en), 64'(0));
            chk("idle_acks", 64'({i_ack, d_ack}), 64'(0));
        end
        @(posedge clk); #1;

        // Randomized mix of single and simultaneous accesses.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            ra  = AW'($urandom_range(0, 63));
            rb  = AW'($urandom_range(0, 63));
            run_txn(sel != 1, sel != 0, ra, rb, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        // MEM_LAT=4 instance: fetch word 0, then a store/load pair.
        run4(1, 6'd0, 0, 64'd0);
        ra = AW'($urandom_range(1, 63));
        run4(0, ra, 1, {$urandom, $urandom});
        run4(0, ra, 0, 64'd0);
        run4(1, ra, 0, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
